// File: rtl/pipeline_ctrl_pkg.sv
// Shared RV32I pipeline types: opcodes, register index, sequencer state.
package rv32i_types;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    st_run     = 2'd0,
    st_bubble  = 2'd1,
    st_ld_fwd  = 2'd2,
    st_flushed = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Wrapping performance counter with a single-cycle increment enable.
module perf_counter
  import rv32i_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (inc) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles,
// memory freezes, taken-branch flushes and the WB load-forward hint.
module pipeline_ctrl
  import rv32i_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  rv32i_opcode      ex_opcode,
  input  rv32i_reg         ex_rd,
  input  rv32i_reg         id_rs1,
  input  rv32i_reg         id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             br_taken_ex,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ld_fwd_wb,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  pipe_state_t state, next_state;
  logic mem_busy, advance, hazard_raw, lu_hazard, br_take;
  logic stall_inc, bubble_inc, flush_inc;

  assign mem_busy = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
  assign advance  = ~mem_busy;

  assign hazard_raw = (ex_opcode == op_load) && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  // ID is a squashed slot after a flush; EX holds a bubble in st_bubble
  assign lu_hazard = hazard_raw && (state != st_flushed) && (state != st_bubble);
  assign br_take   = br_taken_ex && (state != st_bubble);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= st_run;
    else     state <= next_state;
  end

  // Next state: frozen while memory is busy
  always_comb begin
    next_state = state;
    if (advance) begin
      case (state)
        st_bubble: next_state = st_ld_fwd;
        default: begin
          if (br_take)        next_state = st_flushed;
          else if (lu_hazard) next_state = st_bubble;
          else                next_state = st_run;
        end
      endcase
    end
  end

  // Output decode: memory stall > branch flush > load-use bubble > normal
  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    ld_fwd_wb   = 1'b0;
    stall_inc   = 1'b0;
    bubble_inc  = 1'b0;
    flush_inc   = 1'b0;
    if (!rst) begin
      ld_fwd_wb = (state == st_ld_fwd);
      if (mem_busy) begin
        stall_inc = 1'b1;
      end else if (br_take) begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        flush_inc   = 1'b1;
      end else if (lu_hazard) begin
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_id_ex = 1'b1;
        bubble_inc  = 1'b1;
      end else begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
    end
  end

  perf_counter u_stall_ctr  (.clk(clk), .rst(rst), .inc(stall_inc),  .count(stall_cycles));
  perf_counter u_bubble_ctr (.clk(clk), .rst(rst), .inc(bubble_inc), .count(bubble_count));
  perf_counter u_flush_ctr  (.clk(clk), .rst(rst), .inc(flush_inc),  .count(flush_count));

endmodule
